// File: rtl/updn_cnt_gen2.sv
// Up/down counter with programmable upper bound, wrap/saturate/ping-pong modes, tc pulse and sticky flags.
// Optional prescaler on the step enable when UPDN_PRESCALE_EN is defined (adds presc_div input).
module updn_cnt_gen2 #(
   parameter int CNT_WIDTH      = 8,
   parameter int PRESCALE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      up_dn,
   input  logic [1:0]                mode,
   input  logic                      load,
   input  logic [CNT_WIDTH-1:0]      load_val,
   input  logic [CNT_WIDTH-1:0]      max_val,
`ifdef UPDN_PRESCALE_EN
   input  logic [PRESCALE_WIDTH-1:0] presc_div,
`endif
   output logic [CNT_WIDTH-1:0]      count,
   output logic                      dir,
   output logic                      tc,
   output logic                      ovf,
   output logic                      unf
);

   localparam logic [1:0] MODE_WRAP = 2'b00;
   localparam logic [1:0] MODE_SAT  = 2'b01;
   localparam logic [1:0] MODE_PING = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic step;

`ifdef UPDN_PRESCALE_EN
   logic [PRESCALE_WIDTH-1:0] presc;
   logic                      presc_hit;

   assign presc_hit = (presc == presc_div);
   assign step      = en & ~load & presc_hit;

   // Phase is preserved across en=0 so a paused timer resumes where it left off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (load) begin
         presc <= '0;
      end else if (en) begin
         if (presc_hit)
            presc <= '0;
         else
            presc <= presc + 1'b1;
      end
   end
`else
   // Without a prescaler the divider compare is constant-true and folds away.
   logic [PRESCALE_WIDTH-1:0] presc;
   assign presc = '0;
   assign step  = en & ~load & (presc == '0);
`endif

   logic [CNT_WIDTH-1:0] load_clamped;
   logic                 at_max;
   logic                 at_zero;
   logic                 above_max;

   assign load_clamped = (load_val > max_val) ? max_val : load_val;
   assign at_max       = (count == max_val);
   assign at_zero      = (count == CNT_ZERO);
   assign above_max    = (count > max_val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         dir   <= 1'b1;
         tc    <= 1'b0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (load) begin
            count <= load_clamped;
            dir   <= up_dn;
            ovf   <= 1'b0;
            unf   <= 1'b0;
         end else if (step && (mode != MODE_HOLD)) begin
            if (above_max) begin
               // max_val was lowered under the count: clamp and report, nothing else.
               count <= max_val;
               tc    <= 1'b1;
               ovf   <= 1'b1;
            end else begin
               case (mode)
                  MODE_WRAP: begin
                     dir <= up_dn;
                     if (up_dn) begin
                        if (at_max) begin
                           count <= CNT_ZERO;
                           tc    <= 1'b1;
                           ovf   <= 1'b1;
                        end else begin
                           count <= count + CNT_ONE;
                        end
                     end else begin
                        if (at_zero) begin
                           count <= max_val;
                           tc    <= 1'b1;
                           unf   <= 1'b1;
                        end else begin
                           count <= count - CNT_ONE;
                        end
                     end
                  end
                  MODE_SAT: begin
                     dir <= up_dn;
                     if (up_dn) begin
                        if (at_max) begin
                           tc  <= 1'b1;
                           ovf <= 1'b1;
                        end else begin
                           count <= count + CNT_ONE;
                        end
                     end else begin
                        if (at_zero) begin
                           tc  <= 1'b1;
                           unf <= 1'b1;
                        end else begin
                           count <= count - CNT_ONE;
                        end
                     end
                  end
                  MODE_PING: begin
                     if (max_val == CNT_ZERO) begin
                        // Degenerate range: stay at 0, turn around on every step.
                        count <= CNT_ZERO;
                        dir   <= ~dir;
                        tc    <= 1'b1;
                     end else if (dir) begin
                        if (at_max) begin
                           count <= max_val - CNT_ONE;
                           dir   <= 1'b0;
                           tc    <= 1'b1;
                        end else begin
                           count <= count + CNT_ONE;
                        end
                     end else begin
                        if (at_zero) begin
                           count <= CNT_ONE;
                           dir   <= 1'b1;
                           tc    <= 1'b1;
                        end else begin
                           count <= count - CNT_ONE;
                        end
                     end
                  end
                  default: begin
                     count <= count;
                  end
               endcase
            end
         end
      end
   end

endmodule
